// File: rtl/latch_bank_writer.sv
// latch_bank_writer: valid/ready write/clear sequencer for a bank of level-sensitive latches.
// Define LATCH_BANK_WRITER_VERIFY_EN to add the lat_q readback compare and mismatch output.
module latch_bank_writer #(
  parameter int DATA_W     = 8,
  parameter int NUM_LATCH  = 4,
  parameter int ADDR_W     = 2,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_data,
  input  logic                 req_clr,
  output logic [DATA_W-1:0]    lat_d,
  output logic [NUM_LATCH-1:0] lat_en,
  output logic [NUM_LATCH-1:0] lat_clr,
  output logic                 busy,
`ifdef LATCH_BANK_WRITER_VERIFY_EN
  input  logic [NUM_LATCH*DATA_W-1:0] lat_q,
  output logic                 mismatch,
`endif
  output logic                 done
);
  localparam int MAXC = SETUP_CYC > STROBE_CYC ? (SETUP_CYC > HOLD_CYC ? SETUP_CYC : HOLD_CYC)
                                               : (STROBE_CYC > HOLD_CYC ? STROBE_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC > 0 ? SETUP_CYC - 1 : 0);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC > 0 ? HOLD_CYC - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic clr_q, clr_d, done_q, done_d, accept;
  logic [DATA_W-1:0] lat_d_q, lat_d_d;
  logic [NUM_LATCH-1:0] en_q, en_d, lclr_q, lclr_d, onehot;
  assign req_ready = (state_q == IDLE) & ~clear;
  assign accept    = req_valid & req_ready;
  assign busy      = state_q != IDLE;
  assign lat_d     = lat_d_q;
  assign lat_en    = en_q;
  assign lat_clr   = lclr_q;
  assign done      = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    clr_d   = clr_q;
    lat_d_d = lat_d_q;
    if (state_q == IDLE) begin
      if (accept) begin
        state_d = SETUP_CYC > 0 ? SETUP : STROBE;
        cnt_d   = SETUP_CYC > 0 ? SETUP_LD : STROBE_LD;
        addr_d  = req_addr;
        clr_d   = req_clr;
        lat_d_d = req_clr ? '0 : req_data;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      state_d = state_q == SETUP ? STROBE : (state_q == STROBE && HOLD_CYC > 0) ? HOLD : IDLE;
      cnt_d   = state_d == STROBE ? STROBE_LD : state_d == HOLD ? HOLD_LD : '0;
    end
    // Out-of-range addresses still walk every phase but raise no strobe bit.
    onehot = int'(addr_d) < NUM_LATCH ? NUM_LATCH'(1) << addr_d : '0;
    en_d   = (state_d == STROBE && !clr_d) ? onehot : '0;
    lclr_d = (state_d == STROBE && clr_d) ? onehot : '0;
    done_d = state_q != IDLE && state_d == IDLE;
  end
`ifdef LATCH_BANK_WRITER_VERIFY_EN
  logic mm_q, mm_d;
  logic in_range;
  int sel;
  assign mismatch = mm_q;
  always_comb begin
    in_range = int'(addr_q) < NUM_LATCH;
    sel      = in_range ? int'(addr_q) : 0;
    mm_d     = done_d && in_range && (lat_q[sel*DATA_W +: DATA_W] != lat_d_q);
  end
  always_ff @(posedge clock or posedge clear)
    if (clear) mm_q <= 1'b0;
    else mm_q <= mm_d;
`endif
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      clr_q   <= 1'b0;
      lat_d_q <= '0;
      en_q    <= '0;
      lclr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      clr_q   <= clr_d;
      lat_d_q <= lat_d_d;
      en_q    <= en_d;
      lclr_q  <= lclr_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_latch_bank_writer.sv
// tb_latch_bank_writer: scoreboard bench for the default build and a no-setup/no-hold variant
// with 3-bit addresses; stimulus queues expectations, per-DUT monitors pop them on done.
module tb_latch_bank_writer;
  typedef struct {
    logic [7:0] d;
    logic [3:0] en, cl;
    int first, cnt, lat;
    logic mm;
  } exp_t;
  logic clock = 1'b0, clear = 1'b1, v1 = 1'b0, v2 = 1'b0, rclr = 1'b0, stuck = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] data = '0;
  logic rdy1, busy1, done1, rdy2, busy2, done2;
  logic [7:0] d1, d2;
  logic [3:0] en1, lc1, en2, lc2;
  exp_t q1[$], q2[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clock = ~clock;
`ifdef LATCH_BANK_WRITER_VERIFY_EN
  logic mm1, mm2;
  logic [7:0] mem [4];
  logic [31:0] lat_q1;
  assign lat_q1 = {mem[3], mem[2], mem[1], mem[0]};
  always @(posedge clock)
    for (int i = 0; i < 4; i++) begin
      if (clear) mem[i] <= 8'h00;
      else if (en1[i]) mem[i] <= (stuck && i == 0) ? 8'h00 : d1;
      else if (lc1[i]) mem[i] <= 8'h00;
    end
`endif
  latch_bank_writer dut1 (
    .clock(clock), .clear(clear), .req_valid(v1), .req_ready(rdy1), .req_addr(addr[1:0]),
    .req_data(data), .req_clr(rclr), .lat_d(d1), .lat_en(en1), .lat_clr(lc1), .busy(busy1),
`ifdef LATCH_BANK_WRITER_VERIFY_EN
    .lat_q(lat_q1), .mismatch(mm1),
`endif
    .done(done1));
  latch_bank_writer #(.ADDR_W(3), .SETUP_CYC(0), .HOLD_CYC(0)) dut2 (
    .clock(clock), .clear(clear), .req_valid(v2), .req_ready(rdy2), .req_addr(addr),
    .req_data(data), .req_clr(rclr), .lat_d(d2), .lat_en(en2), .lat_clr(lc2), .busy(busy2),
`ifdef LATCH_BANK_WRITER_VERIFY_EN
    .lat_q(32'h0), .mismatch(mm2),
`endif
    .done(done2));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  int cyc = 0, acc1 = 0, f1 = 0, c1 = 0, acc2 = 0, f2 = 0, c2 = 0;
  logic fl1 = 1'b0, fl2 = 1'b0;
  logic [3:0] ea1, ca1, ea2, ca2;
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (clear) fl1 = 1'b0;
    else begin
      if (fl1 && !done1) begin
        chk("busy_ready1", {30'd0, busy1, rdy1}, 32'd2);
        chk("overlap1", {31'd0, en1 != 0 && lc1 != 0}, 32'd0);
        if (en1 != 0 || lc1 != 0) begin
          if (c1 == 0) f1 = cyc - acc1;
          c1++; ea1 |= en1; ca1 |= lc1;
        end
      end
      if (done1) begin
        if (q1.size() == 0) chk("unexpected_done1", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("lat_d1", d1, e.d); chk("en1", ea1, e.en); chk("clr1", ca1, e.cl);
          chk("first1", f1, e.first); chk("cnt1", c1, e.cnt); chk("lat1", cyc - acc1, e.lat);
          chk("ready_at_done1", rdy1, 1);
`ifdef LATCH_BANK_WRITER_VERIFY_EN
          chk("mm1", mm1, e.mm);
`endif
        end
        fl1 = 1'b0;
      end
      if (v1 && rdy1) begin
        fl1 = 1'b1; acc1 = cyc; f1 = 0; c1 = 0; ea1 = '0; ca1 = '0;
      end
    end
  end
  always @(negedge clock) begin
    exp_t e;
    if (clear) fl2 = 1'b0;
    else begin
      if (fl2 && !done2) begin
        chk("busy_ready2", {30'd0, busy2, rdy2}, 32'd2);
        if (en2 != 0 || lc2 != 0) begin
          if (c2 == 0) f2 = cyc - acc2;
          c2++; ea2 |= en2; ca2 |= lc2;
        end
      end
      if (done2) begin
        if (q2.size() == 0) chk("unexpected_done2", 32'd1, 32'd0);
        else begin
          e = q2.pop_front();
          chk("lat_d2", d2, e.d); chk("en2", ea2, e.en); chk("clr2", ca2, e.cl);
          chk("first2", f2, e.first); chk("cnt2", c2, e.cnt); chk("lat2", cyc - acc2, e.lat);
`ifdef LATCH_BANK_WRITER_VERIFY_EN
          chk("mm2", mm2, e.mm);
`endif
        end
        fl2 = 1'b0;
      end
      if (v2 && rdy2) begin
        fl2 = 1'b1; acc2 = cyc; f2 = 0; c2 = 0; ea2 = '0; ca2 = '0;
      end
    end
  end
  task automatic send(input int which, input logic [2:0] a, input logic [7:0] d, input logic c,
                      input bit push, input bit keep, input exp_t e);
    addr = a; data = d; rclr = c;
    if (which == 1) v1 = 1'b1; else v2 = 1'b1;
    for (int i = 0; i < 20 && !(which == 1 ? rdy1 : rdy2); i++) @(posedge clock) #1;
    chk("accept_wait", {31'd0, which == 1 ? rdy1 : rdy2}, 32'd1);
    if (push && which == 1) q1.push_back(e);
    if (push && which != 1) q2.push_back(e);
    @(posedge clock) #1;
    if (!keep) begin v1 = 1'b0; v2 = 1'b0; end
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && (q1.size() + q2.size()) != 0; i++) @(posedge clock);
    chk("drain", q1.size() + q2.size(), 0);
    @(posedge clock) #1;
  endtask
  initial begin
    #2;
    chk("rst_outs1", {d1, en1, lc1, busy1, done1, rdy1}, 0);
    chk("rst_outs2", {d2, en2, lc2, busy2, done2, rdy2}, 0);
`ifdef LATCH_BANK_WRITER_VERIFY_EN
    chk("rst_mm1", mm1, 0);
`endif
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    #1 chk("post_rst1", {busy1, rdy1}, 2'b01);
    @(posedge clock) #1;
    send(1, 3'd2, 8'hA5, 1'b0, 1, 0, '{8'hA5, 4'b0100, 4'b0000, 2, 2, 5, 1'b0});
    drain();
    repeat (3) @(posedge clock) #1;
    chk("idle_hold_lat_d", d1, 8'hA5);
    send(1, 3'd1, 8'h5A, 1'b1, 1, 0, '{8'h00, 4'b0000, 4'b0010, 2, 2, 5, 1'b0});
    drain();
    send(1, 3'd0, 8'h11, 1'b0, 1, 1, '{8'h11, 4'b0001, 4'b0000, 2, 2, 5, 1'b0});
    send(1, 3'd3, 8'h33, 1'b0, 1, 0, '{8'h33, 4'b1000, 4'b0000, 2, 2, 5, 1'b0});
    drain();
    stuck = 1'b1;
    send(1, 3'd0, 8'hFF, 1'b0, 1, 0, '{8'hFF, 4'b0001, 4'b0000, 2, 2, 5, 1'b1});
    drain();
    stuck = 1'b0;
    send(1, 3'd0, 8'hFF, 1'b0, 1, 0, '{8'hFF, 4'b0001, 4'b0000, 2, 2, 5, 1'b0});
    drain();
    // Abort a write mid-strobe: outputs must drop without waiting for a clock edge.
    send(1, 3'd1, 8'h99, 1'b0, 0, 0, '{8'h0, 4'b0, 4'b0, 0, 0, 0, 1'b0});
    @(posedge clock) #1;
    chk("pre_abort_en", en1, 4'b0010);
    clear = 1'b1;
    #1 chk("abort_outs", {d1, en1, lc1, busy1, done1, rdy1}, 0);
    @(posedge clock) #1 clear = 1'b0;
    #1 chk("abort_release", {busy1, rdy1}, 2'b01);
    repeat (8) @(posedge clock);
    #1;
    send(2, 3'd2, 8'hC3, 1'b0, 1, 0, '{8'hC3, 4'b0100, 4'b0000, 1, 2, 3, 1'b1});
    drain();
    send(2, 3'd5, 8'h7E, 1'b0, 1, 0, '{8'h7E, 4'b0000, 4'b0000, 0, 0, 3, 1'b0});
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
